// File: rtl/i2c_dice_regbank.sv
// rtl/i2c_dice_regbank.sv - I2C application-side register bank with dice roller and tick counter
module i2c_dice_regbank #(
   parameter logic [7:0]  ID_VALUE  = 8'hD1,
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   parameter logic [7:0]  MAX_SIDES = 8'd100
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rw,
   input  logic [7:0] addr,
   input  logic       wen,
   input  logic [7:0] wdata,
   input  logic       rdata_used,
   output logic [7:0] rdata,
   output logic       roll_busy
);

   localparam logic [7:0] A_ID     = 8'h00;
   localparam logic [7:0] A_CTRL   = 8'h01;
   localparam logic [7:0] A_SIDES  = 8'h02;
   localparam logic [7:0] A_RESULT = 8'h03;
   localparam logic [7:0] A_STATUS = 8'h04;
   localparam logic [7:0] A_CNT_L  = 8'h05;
   localparam logic [7:0] A_CNT_H  = 8'h06;

   typedef enum logic {S_IDLE = 1'b0, S_ROLL = 1'b1} state_t;

   state_t      state, state_nxt;
   logic        cnt_en;
   logic [7:0]  sides, result;
   logic        roll_done, wr_err;
   logic [15:0] cnt, lfsr;
   logic [7:0]  hi_pend, hi_shadow;
   logic        wr_ctrl, wr_sides, wr_status, wr_bad;
   logic        roll_req, roll_hit, lfsr_fb;
   logic [6:0]  roll_val;
   logic [7:0]  sides_clamped, rd_mux;
   wire         unused_rw = rw;

   assign wr_ctrl   = wen && (addr == A_CTRL);
   assign wr_sides  = wen && (addr == A_SIDES);
   assign wr_status = wen && (addr == A_STATUS);
   assign wr_bad    = wen && !((addr == A_CTRL) || (addr == A_SIDES) || (addr == A_STATUS));
   assign roll_req  = wr_ctrl && wdata[1];
   assign roll_val  = lfsr[6:0];
   assign roll_hit  = (state == S_ROLL) && ({1'b0, roll_val} < sides);
   assign roll_busy = (state == S_ROLL);
   assign lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

   always_comb begin
      sides_clamped = wdata;
      if (wdata < 8'd2)
         sides_clamped = 8'd2;
      else if (wdata > MAX_SIDES)
         sides_clamped = MAX_SIDES;
   end

   // Rejection sampling: keep drawing 7-bit values until one lands below SIDES
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (roll_req) state_nxt = S_ROLL;
         S_ROLL: if (roll_hit) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      rd_mux = 8'hFF;
      case (addr)
         A_ID:     rd_mux = ID_VALUE;
         A_CTRL:   rd_mux = {7'd0, cnt_en};
         A_SIDES:  rd_mux = sides;
         A_RESULT: rd_mux = result;
         A_STATUS: rd_mux = {5'd0, roll_busy, wr_err, roll_done};
         A_CNT_L:  rd_mux = cnt[7:0];
         A_CNT_H:  rd_mux = hi_shadow;
         default:  rd_mux = 8'hFF;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         lfsr   <= LFSR_SEED;
         result <= 8'd0;
      end else begin
         state <= state_nxt;
         lfsr  <= {lfsr[14:0], lfsr_fb};
         if (roll_hit)
            result <= {1'b0, roll_val} + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_en    <= 1'b0;
         sides     <= 8'd6;
         roll_done <= 1'b0;
         wr_err    <= 1'b0;
      end else begin
         if (wr_ctrl)
            cnt_en <= wdata[0];
         if (wr_sides)
            sides <= sides_clamped;
         // Hardware set beats a same-cycle write-1-to-clear
         if (roll_hit)
            roll_done <= 1'b1;
         else if (wr_status && wdata[0])
            roll_done <= 1'b0;
         if (wr_bad)
            wr_err <= 1'b1;
         else if (wr_status && wdata[1])
            wr_err <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= 16'd0;
      else if (wr_ctrl && wdata[2])
         cnt <= 16'd0;
      else if (cnt_en)
         cnt <= cnt + 16'd1;
   end

   // hi_pend tracks the high byte alongside every CNT_L sample so the later
   // CNT_H read returns the half that matches the low byte the slave took
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata     <= 8'd0;
         hi_pend   <= 8'd0;
         hi_shadow <= 8'd0;
      end else begin
         rdata <= rd_mux;
         if (addr == A_CNT_L)
            hi_pend <= cnt[15:8];
         if (rdata_used && (addr == A_CNT_L))
            hi_shadow <= hi_pend;
      end
   end

endmodule

// File: tb/tb_i2c_dice_regbank.sv
// tb/tb_i2c_dice_regbank.sv - directed self-checking bench for i2c_dice_regbank
module tb_i2c_dice_regbank;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rw = 1'b0;
   logic [7:0] addr = 8'h00;
   logic       wen = 1'b0;
   logic [7:0] wdata = 8'h00;
   logic       rdata_used = 1'b0;
   logic [7:0] rdata;
   logic       roll_busy;

   int errors = 0;
   int checks = 0;

   i2c_dice_regbank dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rw         (rw),
      .addr       (addr),
      .wen        (wen),
      .wdata      (wdata),
      .rdata_used (rdata_used),
      .rdata      (rdata),
      .roll_busy  (roll_busy)
   );

   always #5 clk = ~clk;

   task automatic read_reg(input logic [7:0] a, output logic [7:0] d);
      addr = a;
      @(negedge clk);
      d = rdata;
   endtask

   task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
      addr  = a;
      wdata = d;
      wen   = 1'b1;
      @(negedge clk);
      wen   = 1'b0;
   endtask

   task automatic wait_roll();
      int n = 0;
      while (roll_busy && n < 2000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (roll_busy) begin
         errors++;
         $display("FAIL roll_timeout: roll_busy=%0b after %0d cycles, required 0", roll_busy, n);
      end
   endtask

   task automatic test_reset();
      logic [7:0] d;
      logic [7:0] ra [8] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h7F};
      logic [7:0] rv [8] = '{8'hD1, 8'h00, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
      repeat (2) @(negedge clk);
      checks++;
      if (rdata !== 8'h00 || roll_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_out: rdata=%h busy=%b, required 00 0", rdata, roll_busy);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         read_reg(ra[i], d);
         checks++;
         if (d !== rv[i]) begin
            errors++;
            $display("FAIL reset_read[%h]: got %h, required %h", ra[i], d, rv[i]);
         end
      end
   endtask

   task automatic test_sides_clamp();
      logic [7:0] d;
      logic [7:0] wv [6] = '{8'h00, 8'hC8, 8'h0C, 8'h01, 8'h65, 8'h64};
      logic [7:0] ev [6] = '{8'h02, 8'h64, 8'h0C, 8'h02, 8'h64, 8'h64};
      for (int i = 0; i < 6; i++) begin
         write_reg(8'h02, wv[i]);
         read_reg(8'h02, d);
         checks++;
         if (d !== ev[i]) begin
            errors++;
            $display("FAIL sides_clamp[%h]: got %h, required %h", wv[i], d, ev[i]);
         end
      end
      write_reg(8'h02, 8'h0C);
   endtask

   task automatic test_roll();
      logic [7:0] d;
      logic [5:0] seen = 6'd0;
      write_reg(8'h02, 8'h06);
      checks++;
      if (roll_busy !== 1'b0) begin
         errors++;
         $display("FAIL roll_idle: busy=%b, required 0", roll_busy);
      end
      write_reg(8'h01, 8'h02);
      checks++;
      if (roll_busy !== 1'b1) begin
         errors++;
         $display("FAIL roll_start: busy=%b, required 1", roll_busy);
      end
      wait_roll();
      read_reg(8'h03, d);
      checks++;
      if (d < 8'd1 || d > 8'd6) begin
         errors++;
         $display("FAIL roll_result: got %h, required 01..06", d);
      end
      read_reg(8'h04, d);
      checks++;
      if (d !== 8'h01) begin
         errors++;
         $display("FAIL roll_status: got %h, required 01", d);
      end
      for (int i = 0; i < 200; i++) begin
         write_reg(8'h01, 8'h02);
         wait_roll();
         read_reg(8'h03, d);
         checks++;
         if (d < 8'd1 || d > 8'd6) begin
            errors++;
            $display("FAIL roll_range[%0d]: got %h, required 01..06", i, d);
         end else begin
            seen[d - 8'd1] = 1'b1;
         end
      end
      checks++;
      if (seen !== 6'h3F) begin
         errors++;
         $display("FAIL roll_cover: seen=%b, required 111111", seen);
      end
   endtask

   task automatic test_status();
      logic [7:0] d;
      int n = 0;
      write_reg(8'h00, 8'h55);
      read_reg(8'h04, d);
      checks++;
      if (d !== 8'h03) begin
         errors++;
         $display("FAIL status_wr_err: got %h, required 03", d);
      end
      read_reg(8'h00, d);
      checks++;
      if (d !== 8'hD1) begin
         errors++;
         $display("FAIL id_unchanged: got %h, required d1", d);
      end
      write_reg(8'h04, 8'h03);
      read_reg(8'h04, d);
      checks++;
      if (d !== 8'h00) begin
         errors++;
         $display("FAIL status_w1c: got %h, required 00", d);
      end
      write_reg(8'h7F, 8'h00);
      read_reg(8'h04, d);
      checks++;
      if (d !== 8'h02) begin
         errors++;
         $display("FAIL status_unmapped: got %h, required 02", d);
      end
      write_reg(8'h04, 8'h02);
      // Hold a roll_done W1C every cycle of the roll, including the completion edge
      write_reg(8'h01, 8'h02);
      while (roll_busy && n < 2000) begin
         addr  = 8'h04;
         wdata = 8'h01;
         wen   = 1'b1;
         @(negedge clk);
         n++;
      end
      wen = 1'b0;
      read_reg(8'h04, d);
      checks++;
      if (d !== 8'h01) begin
         errors++;
         $display("FAIL status_set_wins: got %h, required 01", d);
      end
   endtask

   task automatic test_counter(input int n_edges, input logic [15:0] expv);
      logic [7:0] lo, hi, d;
      write_reg(8'h01, 8'h05);
      addr = 8'h05;
      repeat (n_edges) @(negedge clk);
      lo = rdata;
      rdata_used = 1'b1;
      @(negedge clk);
      rdata_used = 1'b0;
      repeat (300) @(negedge clk);
      read_reg(8'h06, hi);
      checks++;
      if ({hi, lo} !== expv) begin
         errors++;
         $display("FAIL cnt_atomic: got %h, required %h", {hi, lo}, expv);
      end
      read_reg(8'h01, d);
      checks++;
      if (d !== 8'h01) begin
         errors++;
         $display("FAIL ctrl_read: got %h, required 01", d);
      end
      write_reg(8'h01, 8'h00);
   endtask

   task automatic test_reset_midop();
      logic [7:0] d;
      logic [7:0] ra [6] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      logic [7:0] rv [6] = '{8'h00, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00};
      write_reg(8'h02, 8'h0C);
      write_reg(8'h01, 8'h01);
      repeat (50) @(negedge clk);
      write_reg(8'h01, 8'h03);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (roll_busy !== 1'b0 || rdata !== 8'h00) begin
         errors++;
         $display("FAIL async_reset: busy=%b rdata=%h, required 0 00", roll_busy, rdata);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         read_reg(ra[i], d);
         checks++;
         if (d !== rv[i]) begin
            errors++;
            $display("FAIL midop_reset[%h]: got %h, required %h", ra[i], d, rv[i]);
         end
      end
      write_reg(8'h01, 8'h02);
      wait_roll();
      read_reg(8'h03, d);
      checks++;
      if (d < 8'd1 || d > 8'd6) begin
         errors++;
         $display("FAIL post_reset_roll: got %h, required 01..06", d);
      end
      read_reg(8'h04, d);
      checks++;
      if (d !== 8'h01) begin
         errors++;
         $display("FAIL post_reset_status: got %h, required 01", d);
      end
   endtask

   initial begin
      test_reset();
      test_sides_clamp();
      test_roll();
      test_status();
      test_counter(16'h1235, 16'h1234);
      test_counter(16'h0100, 16'h00FF);
      test_reset_midop();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/i2c_dice_regbank.md
Name: i2c_dice_regbank

Overview:
- Register bank sitting directly downstream of the I2C slave's application interface (rw/addr/wen/wdata/rdata_used/rdata).
- Decodes byte writes into control registers and supplies registered read data back to the slave.
- Contains a bus-driven dice roller (LFSR plus rejection sampling), a sticky status register and a 16-bit free-running tick counter with atomic low/high read.
- Gives the I2C path of the chip a real function alongside the button-driven dice.

Parameters:
- ID_VALUE, 8'hD1, constant returned at address 0x00.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.
- MAX_SIDES, 8'd100, upper clamp for SIDES.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- rw  in  1  transaction direction from slave, 1 = read; informational only, not used for decode.
- addr  in  8  register address from slave, held stable for the whole byte.
- wen  in  1  one-cycle write strobe; wdata is valid in that cycle.
- wdata  in  8  write data.
- rdata_used  in  1  one-cycle pulse: slave has latched rdata for transmission.
- rdata  out  8  registered read data for the current addr.
- roll_busy  out  1  high while a roll is in progress.

Behaviour:
- Reset (async on rst_n low):
  - rdata=0, CTRL=0, SIDES=6, RESULT=0, STATUS=0, cnt=0, hi_pend=0, hi_shadow=0.
  - lfsr=LFSR_SEED, FSM=IDLE, roll_busy=0.
  - Reset mid-roll aborts the roll; RESULT stays 0.
- Register map:
  - 0x00 ID: RO = ID_VALUE.
  - 0x01 CTRL: bit0 cnt_en (RW); bit1 roll (write-1 strobe, reads 0); bit2 cnt_clr (write-1 strobe, reads 0); bits7:3 read 0.
  - 0x02 SIDES: RW. Writes <2 store 2; writes >MAX_SIDES store MAX_SIDES.
  - 0x03 RESULT: RO, last roll in 1..SIDES.
  - 0x04 STATUS: bit0 roll_done (sticky); bit1 wr_err (sticky); bit2 busy (live, RO). Write 1 to bit0/bit1 clears that bit.
  - 0x05 CNT_L: RO = cnt[7:0].
  - 0x06 CNT_H: RO = hi_shadow.
  - Unmapped addresses read 8'hFF.
  - Any write to an RO or unmapped address sets wr_err and has no other effect.
- Read path:
  - Every cycle, rdata <= mux(addr), so latency is 1 cycle after an addr change.
  - While addr==0x05: hi_pend <= cnt[15:8] in the same cycle rdata samples cnt[7:0].
  - On rdata_used with addr==0x05: hi_shadow <= hi_pend. Reading L then H therefore returns one coherent 16-bit sample.
- Counter:
  - When cnt_en=1, cnt increments by 1 every cycle; wraps 0xFFFF->0x0000.
  - cnt_clr forces cnt=0 in the cycle after the write and overrides the increment.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11; shifts every cycle, including IDLE.
- Roll FSM:
  - IDLE: write of CTRL with bit1=1 -> ROLL; roll_busy=1 from the next cycle.
  - ROLL: each cycle v=lfsr[6:0]. If v<SIDES: RESULT<=v+1, set roll_done, -> IDLE. Otherwise stay in ROLL.
  - Roll strobe while in ROLL is ignored, with no error.
  - Writing SIDES during ROLL takes effect on the next comparison.
- Simultaneous events:
  - roll_done set and a W1C of roll_done in the same cycle: set wins.
  - wr_err set and a W1C of wr_err in the same cycle: set wins.
  - wen and rdata_used in the same cycle: both are processed independently.

Test Plan:
- Reset, addr=0x00, wait 1 clk -> rdata=0xD1. addr=0x02 -> 0x06. addr=0x03 -> 0x00. addr=0x7F -> 0xFF.
- Write SIDES 0x00 -> reads 0x02. Write 0xC8 -> reads 0x64. Write 0x0C -> reads 0x0C.
- SIDES=6, write CTRL=0x02 -> roll_busy rises next cycle. On drop: RESULT in 1..6 and STATUS=0x01. 200 rolls: every value 1..6 seen, none outside.
- Write 0x55 to addr 0x00 -> STATUS bit1=1, ID unchanged. Write STATUS=0x03 -> STATUS=0x00. W1C in the same cycle as roll completion -> bit0 remains 1.
- CTRL=0x01, run 0x1234 cycles, then read CNT_L with rdata_used, wait 300 cycles, read CNT_H -> {H,L} equals the counter value at the L sample. Repeat at 0x00FF->0x0100 wrap.
- Assert rst_n low mid-roll and mid-count -> all registers at reset values asynchronously, roll_busy=0, next roll behaves normally.
